// File: rtl/cdb_scheduler_pkg.sv
// Shared types and constants for the common-data-bus scheduler.
package cdb_scheduler_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned FU_ID_W = 3;

    // Result payload broadcast on the CDB
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_bus;

    // One reservation slot: owner of the broadcast in that cycle
    typedef struct packed {
        logic               valid;
        logic [FU_ID_W-1:0] fu_id;
    } rsv_entry_t;

    localparam logic [FU_ID_W-1:0] FU_INT  = 3'd0;
    localparam logic [FU_ID_W-1:0] FU_MEM  = 3'd1;
    localparam logic [FU_ID_W-1:0] FU_MULT = 3'd2;
    localparam logic [FU_ID_W-1:0] FU_DIV  = 3'd3;

endpackage

// File: rtl/cdb_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: first request at or after ptr wins, one-hot grant.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // Scan circularly from ptr, grant the first requester
    always_comb begin
        int unsigned idx;
        logic        found;
        gnt   = '0;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[PW'(idx)]) begin
                gnt[PW'(idx)] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_scheduler.sv
// CDB reservation scheduler: grants issues only into free broadcast slots and drives the owner's result.
module cdb_scheduler
    import cdb_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_FU          = 4,
    parameter  int unsigned MAX_LAT         = 8,
    parameter  int unsigned FU_LAT [NUM_FU] = '{1, 1, 4, 7},
    localparam int unsigned ID_W            = $clog2(NUM_FU),
    localparam int unsigned BUSY_W          = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_FU-1:0] issue_req,
    output logic [NUM_FU-1:0] issue_gnt,
    input  logic              flush,
    input  cdb_bus            fu_result [NUM_FU],
    output cdb_bus            CDB_output,
    output logic              cdb_valid,
    output logic [ID_W-1:0]   cdb_fu_id,
    output logic [BUSY_W-1:0] rsv_busy
);

    // FUs sharing this FU's latency compete for the same slot
    function automatic logic [NUM_FU-1:0] lat_mask(input int unsigned g);
        logic [NUM_FU-1:0] m;
        m = '0;
        for (int unsigned j = 0; j < NUM_FU; j++) m[j] = (FU_LAT[j] == FU_LAT[g]);
        return m;
    endfunction

    // True for the lowest FU id of each distinct latency
    function automatic bit first_of_lat(input int unsigned g);
        for (int unsigned j = 0; j < g; j++) if (FU_LAT[j] == FU_LAT[g]) return 1'b0;
        return 1'b1;
    endfunction

    rsv_entry_t        rsv      [MAX_LAT];
    rsv_entry_t        rsv_nxt  [MAX_LAT];
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_ptr_nxt;
    logic [BUSY_W-1:0] busy_nxt;
    logic [NUM_FU-1:0] free_c;
    logic [NUM_FU-1:0] elig_c;
    logic [NUM_FU-1:0] lose_c;
    logic [NUM_FU-1:0] grp_gnt_c [NUM_FU];

    if (NUM_FU < 2 || NUM_FU > 8) begin : g_bad_num_fu
        $error("cdb_scheduler: NUM_FU must be in 2..8");
    end

    // Target slot after the shift is rsv[L]; a MAX_LAT slot is always fresh
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        if (FU_LAT[i] < 1 || FU_LAT[i] > MAX_LAT) begin : g_bad_lat
            $error("cdb_scheduler: FU_LAT entry out of range 1..MAX_LAT");
        end else if (FU_LAT[i] == MAX_LAT) begin : g_edge
            assign free_c[i] = 1'b1;
        end else begin : g_slot
            assign free_c[i] = !rsv[FU_LAT[i]].valid;
        end
    end

    assign elig_c = issue_req & free_c & {NUM_FU{!flush}};

    // One arbiter per distinct latency value
    for (genvar g = 0; g < NUM_FU; g++) begin : g_grp
        if (first_of_lat(g)) begin : g_arb
            localparam logic [NUM_FU-1:0] MASK = lat_mask(g);
            rr_arbiter #(.N(NUM_FU)) u_arb (
                .req (elig_c & MASK),
                .ptr (rr_ptr),
                .gnt (grp_gnt_c[g])
            );
        end else begin : g_none
            assign grp_gnt_c[g] = '0;
        end
    end

    // Merge the per-latency grants
    always_comb begin
        issue_gnt = '0;
        for (int unsigned g = 0; g < NUM_FU; g++) issue_gnt = issue_gnt | grp_gnt_c[g];
    end

    assign lose_c = elig_c & ~issue_gnt;

    // Move priority to the nearest FU that lost an arbitration
    always_comb begin
        int unsigned idx;
        logic        found;
        rr_ptr_nxt = rr_ptr;
        idx        = 0;
        found      = 1'b0;
        for (int unsigned k = 1; k < NUM_FU; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_FU;
            if (!found && lose_c[ID_W'(idx)]) begin
                rr_ptr_nxt = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

    // Shift the table, book new grants, clear everything on flush
    always_comb begin
        for (int unsigned k = 0; k < MAX_LAT; k++) begin
            if (k + 1 < MAX_LAT) rsv_nxt[k] = rsv[k + 1];
            else                 rsv_nxt[k] = '0;
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (issue_gnt[i] && (FU_LAT[i] - 1 == k)) begin
                    rsv_nxt[k].valid = 1'b1;
                    rsv_nxt[k].fu_id = FU_ID_W'(i);
                end
            end
            if (flush) rsv_nxt[k] = '0;
        end
    end

    // Occupancy of the table as it will be after this edge
    always_comb begin
        busy_nxt = '0;
        for (int unsigned k = 0; k < MAX_LAT; k++) busy_nxt = busy_nxt + BUSY_W'(rsv_nxt[k].valid);
    end

    // Reservation table, priority pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < MAX_LAT; k++) rsv[k] <= '0;
            rr_ptr   <= '0;
            rsv_busy <= '0;
        end else begin
            for (int unsigned k = 0; k < MAX_LAT; k++) rsv[k] <= rsv_nxt[k];
            rr_ptr   <= rr_ptr_nxt;
            rsv_busy <= busy_nxt;
        end
    end

    // Slot due this cycle drives the bus; idle bus is all-zero
    always_comb begin
        CDB_output = '0;
        cdb_valid  = 1'b0;
        cdb_fu_id  = '0;
        if (rsv[0].valid) begin
            cdb_valid  = 1'b1;
            cdb_fu_id  = ID_W'(rsv[0].fu_id);
            CDB_output = fu_result[ID_W'(rsv[0].fu_id)];
        end
    end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Self-checking bench for cdb_scheduler (4 FUs, latencies 1,1,4,7, depth 8).
module tb_cdb_scheduler;
    import cdb_scheduler_pkg::*;

    localparam int NFU  = 4;
    localparam int MLAT = 8;
    localparam int LAT [NFU] = '{1, 1, 4, 7};

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] issue_req;
    logic [3:0] issue_gnt;
    logic       flush;
    cdb_bus     fu_result [NFU];
    cdb_bus     CDB_output;
    logic       cdb_valid;
    logic [1:0] cdb_fu_id;
    logic [3:0] rsv_busy;

    int total = 0;
    int bad   = 0;

    cdb_scheduler #(.NUM_FU(4), .MAX_LAT(8), .FU_LAT('{1, 1, 4, 7})) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_req  (issue_req),
        .issue_gnt  (issue_gnt),
        .flush      (flush),
        .fu_result  (fu_result),
        .CDB_output (CDB_output),
        .cdb_valid  (cdb_valid),
        .cdb_fu_id  (cdb_fu_id),
        .rsv_busy   (rsv_busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] r, input logic f);
        issue_req = r;
        flush     = f;
        for (int i = 0; i < NFU; i++) begin
            fu_result[i].tag  = TAG_W'($urandom);
            fu_result[i].data = $urandom;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(4'b0000, 1'b0);
        next_cycle();
        @(negedge clk);
        total++; if (cdb_valid !== 1'b0 || rsv_busy !== 4'd0) begin bad++; $display("FAIL reset_hold valid=%b busy=%0d exp 0/0", cdb_valid, rsv_busy); end
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(4'b0000, 1'b0);
            @(negedge clk);
            total++;
            if (cdb_valid !== 1'b0 || CDB_output !== '0 || rsv_busy !== 4'd0 || issue_gnt !== 4'b0000 || cdb_fu_id !== 2'd0) begin
                bad++;
                $display("FAIL reset_idle c=%0d valid=%b out=%h busy=%0d gnt=%b id=%0d exp all zero", c, cdb_valid, CDB_output, rsv_busy, issue_gnt, cdb_fu_id);
            end
            next_cycle();
        end
    endtask

    task automatic test_single_fu3();
        for (int c = 0; c < 15; c++) begin
            logic [3:0] eg;
            eg = (c == 5) ? 4'b1000 : 4'b0000;
            drive(eg, 1'b0);
            @(negedge clk);
            total++; if (issue_gnt !== eg) begin bad++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, issue_gnt, eg); end
            total++; if (cdb_valid !== 1'(c == 12)) begin bad++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, cdb_valid, c == 12); end
            if (c == 12) begin
                total++;
                if (cdb_fu_id !== 2'(FU_DIV) || CDB_output !== fu_result[3]) begin
                    bad++; $display("FAIL single_bcast id=%0d out=%h exp id=3 out=%h", cdb_fu_id, CDB_output, fu_result[3]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_pair_rr();
        for (int c = 0; c < 7; c++) begin
            logic [3:0] eg;
            eg = (c >= 4) ? 4'b0000 : ((c % 2 == 0) ? 4'b0001 : 4'b0010);
            drive((c < 4) ? 4'b0011 : 4'b0000, 1'b0);
            @(negedge clk);
            total++; if (issue_gnt !== eg) begin bad++; $display("FAIL pair_gnt c=%0d got=%b exp=%b", c, issue_gnt, eg); end
            total++; if (cdb_valid !== 1'(c >= 1 && c <= 4)) begin bad++; $display("FAIL pair_valid c=%0d got=%b", c, cdb_valid); end
            if (c >= 1 && c <= 4) begin
                total++;
                if (cdb_fu_id !== 2'((c - 1) % 2) || CDB_output !== fu_result[(c - 1) % 2]) begin
                    bad++; $display("FAIL pair_bcast c=%0d id=%0d exp=%0d", c, cdb_fu_id, (c - 1) % 2);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_slot_conflict();
        for (int c = 0; c < 18; c++) begin
            logic [3:0] r, eg;
            int         eid;
            r   = (c == 10) ? 4'b0100 : ((c == 13 || c == 14) ? 4'b0001 : 4'b0000);
            eg  = (c == 10) ? 4'b0100 : ((c == 14) ? 4'b0001 : 4'b0000);
            eid = (c == 14) ? 2 : ((c == 15) ? 0 : -1);
            drive(r, 1'b0);
            @(negedge clk);
            total++; if (issue_gnt !== eg) begin bad++; $display("FAIL conflict_gnt c=%0d got=%b exp=%b", c, issue_gnt, eg); end
            total++; if (cdb_valid !== 1'(eid >= 0)) begin bad++; $display("FAIL conflict_valid c=%0d got=%b exp=%b", c, cdb_valid, eid >= 0); end
            if (eid >= 0) begin
                total++;
                if (cdb_fu_id !== 2'(eid) || CDB_output !== fu_result[eid]) begin
                    bad++; $display("FAIL conflict_bcast c=%0d id=%0d exp=%0d", c, cdb_fu_id, eid);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 9; c++) begin
            logic [3:0] eg;
            eg = (c < 3) ? 4'b0100 : 4'b0000;
            drive(eg, 1'b0);
            @(negedge clk);
            total++; if (issue_gnt !== eg) begin bad++; $display("FAIL b2b_gnt c=%0d got=%b exp=%b", c, issue_gnt, eg); end
            total++;
            if (cdb_valid !== 1'(c >= 4 && c <= 6) || (c >= 4 && c <= 6 && cdb_fu_id !== 2'd2)) begin
                bad++; $display("FAIL b2b_bcast c=%0d valid=%b id=%0d", c, cdb_valid, cdb_fu_id);
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 11; c++) begin
            logic [3:0] r, eg;
            r  = (c == 0) ? 4'b1000 : ((c == 3) ? 4'b0001 : 4'b0000);
            eg = (c == 0) ? 4'b1000 : 4'b0000;
            drive(r, 1'(c == 3));
            @(negedge clk);
            total++; if (issue_gnt !== eg) begin bad++; $display("FAIL flush_gnt c=%0d got=%b exp=%b", c, issue_gnt, eg); end
            total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_valid c=%0d got=%b exp=0", c, cdb_valid); end
            total++;
            if (rsv_busy !== ((c >= 1 && c <= 3) ? 4'd1 : 4'd0)) begin
                bad++; $display("FAIL flush_busy c=%0d got=%0d exp=%0d", c, rsv_busy, (c >= 1 && c <= 3) ? 1 : 0);
            end
            next_cycle();
        end
        // A broadcast due in the flush cycle still completes
        drive(4'b0001, 1'b0);
        next_cycle();
        drive(4'b0000, 1'b1);
        @(negedge clk);
        total++;
        if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'(FU_INT) || CDB_output !== fu_result[0]) begin
            bad++; $display("FAIL flush_due valid=%b id=%0d exp valid=1 id=0", cdb_valid, cdb_fu_id);
        end
        next_cycle();
        drive(4'b0000, 1'b0);
        @(negedge clk);
        total++; if (rsv_busy !== 4'd0 || cdb_valid !== 1'b0) begin bad++; $display("FAIL flush_after busy=%0d valid=%b exp 0/0", rsv_busy, cdb_valid); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 10; c++) begin
            if (c == 2) rst = 1'b0;
            if (c == 3) rst = 1'b1;
            drive((c == 0) ? 4'b0100 : 4'b0000, 1'b0);
            @(negedge clk);
            if (c == 0) begin
                total++; if (issue_gnt !== 4'b0100) begin bad++; $display("FAIL rstmid_gnt got=%b exp=0100", issue_gnt); end
            end
            if (c == 1) begin
                total++; if (rsv_busy !== 4'd1) begin bad++; $display("FAIL rstmid_busy got=%0d exp=1", rsv_busy); end
            end
            total++; if (cdb_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid c=%0d got=%b exp=0", c, cdb_valid); end
            if (c >= 2) begin
                total++; if (rsv_busy !== 4'd0) begin bad++; $display("FAIL rstmid_clear c=%0d busy=%0d exp=0", c, rsv_busy); end
            end
            next_cycle();
        end
    endtask

    // Reference model: a calendar of booked broadcast cycles keyed by absolute cycle number
    task automatic test_random();
        int         cal [int];
        int         keys [$];
        int         rr, now, newrr, exp_busy, eid;
        bit         loser_found;
        bit [MLAT:0] lat_taken;
        logic [3:0] r, eg;
        logic       f;
        rst = 1'b0;
        drive(4'b0000, 1'b0);
        next_cycle();
        rst = 1'b1;
        rr  = 0;
        now = 0;
        for (int n = 0; n < 500; n++) begin
            r = 4'($urandom);
            f = ($urandom_range(0, 19) == 0);
            drive(r, f);
            eg          = '0;
            newrr       = rr;
            loser_found = 1'b0;
            lat_taken   = '0;
            if (!f) begin
                for (int d = 0; d < NFU; d++) begin
                    int j;
                    j = (rr + d) % NFU;
                    if (r[j] && !cal.exists(now + LAT[j])) begin
                        if (!lat_taken[LAT[j]]) begin
                            eg[j]              = 1'b1;
                            lat_taken[LAT[j]]  = 1'b1;
                        end else if (!loser_found) begin
                            newrr       = j;
                            loser_found = 1'b1;
                        end
                    end
                end
            end
            exp_busy = 0;
            foreach (cal[k]) if (k >= now) exp_busy++;
            eid = cal.exists(now) ? cal[now] : -1;
            @(negedge clk);
            total++; if (issue_gnt !== eg) begin bad++; $display("FAIL rand_gnt n=%0d req=%b flush=%b got=%b exp=%b", n, r, f, issue_gnt, eg); end
            total++; if (rsv_busy !== 4'(exp_busy)) begin bad++; $display("FAIL rand_busy n=%0d got=%0d exp=%0d", n, rsv_busy, exp_busy); end
            total++;
            if (eid < 0) begin
                if (cdb_valid !== 1'b0 || cdb_fu_id !== 2'd0 || CDB_output !== '0) begin
                    bad++; $display("FAIL rand_idle n=%0d valid=%b id=%0d out=%h exp idle", n, cdb_valid, cdb_fu_id, CDB_output);
                end
            end else if (cdb_valid !== 1'b1 || cdb_fu_id !== 2'(eid) || CDB_output !== fu_result[eid]) begin
                bad++; $display("FAIL rand_bcast n=%0d valid=%b id=%0d exp id=%0d", n, cdb_valid, cdb_fu_id, eid);
            end
            next_cycle();
            for (int i = 0; i < NFU; i++) if (eg[i]) cal[now + LAT[i]] = i;
            keys.delete();
            foreach (cal[k]) if (k <= now || f) keys.push_back(k);
            foreach (keys[q]) cal.delete(keys[q]);
            rr = newrr;
            now++;
        end
        drive(4'b0000, 1'b0);
        repeat (MLAT + 1) next_cycle();
    endtask

    initial begin
        rst       = 1'b0;
        issue_req = '0;
        flush     = 1'b0;
        for (int i = 0; i < NFU; i++) fu_result[i] = '0;
        test_reset();
        test_single_fu3();
        test_pair_rr();
        test_slot_conflict();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
